// File: rtl/gng_sign_split.sv
// gng_sign_split
// Converts 16-bit two's-complement noise samples into sign-magnitude form.
// Results are queued in a small FIFO with valid/ready handshakes on both
// sides. Running statistics (sample count, negative count, peak magnitude)
// are kept alongside and can be cleared at any time.
//
// Ports
//   clk, rst      : clock and synchronous active-high reset
//   in_valid      : upstream sample valid
//   in_ready      : FIFO has room (registered state only)
//   in_data       : two's-complement sample
//   out_valid     : FIFO head valid
//   out_ready     : downstream accepts head
//   out_sign      : head sign, 1 = negative
//   out_mag       : head unsigned magnitude
//   clr_stats     : synchronous clear of statistics
//   sample_count  : accepted samples, saturating
//   neg_count     : accepted negative samples, saturating
//   peak_mag      : largest magnitude accepted
module gng_sign_split #(
   parameter int W     = 16,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sign,
   output logic [W-1:0]     out_mag,
   input  logic             clr_stats,
   output logic [CNT_W-1:0] sample_count,
   output logic [CNT_W-1:0] neg_count,
   output logic [W-1:0]     peak_mag
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

   logic          mem_sign [DEPTH];
   logic [W-1:0]  mem_mag  [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;

   logic          push;
   logic          pop;
   logic          in_sign;
   logic [W-1:0]  in_mag;

   logic [CNT_W-1:0] sample_next;
   logic [CNT_W-1:0] neg_next;
   logic [W-1:0]     peak_next;

   // Handshake and conversion. The most negative input negates to itself,
   // which read as unsigned is exactly its magnitude, so no saturation.
   always_comb begin
      in_ready  = (count < DEPTH_CNT);
      out_valid = (count != '0);
      push      = in_valid && in_ready;
      pop       = out_valid && out_ready;
      in_sign   = in_data[W-1];
      in_mag    = in_sign ? (~in_data + W'(1)) : in_data;
      out_sign  = mem_sign[rd_ptr];
      out_mag   = mem_mag[rd_ptr];
   end

   // Storage is written only at the tail, and only when there is room, so the
   // head entry can never change underneath a stalled consumer.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_sign[i] <= 1'b0;
            mem_mag[i]  <= '0;
         end
      end else if (push) begin
         mem_sign[wr_ptr] <= in_sign;
         mem_mag[wr_ptr]  <= in_mag;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two; the occupancy
   // count stays put when a push and a pop land in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // A clear zeroes the statistics first and a push in the same cycle is then
   // applied on top of the cleared values.
   always_comb begin
      sample_next = clr_stats ? '0 : sample_count;
      neg_next    = clr_stats ? '0 : neg_count;
      peak_next   = clr_stats ? '0 : peak_mag;
      if (push) begin
         if (sample_next != '1)           sample_next = sample_next + CNT_W'(1);
         if (in_sign && neg_next != '1)   neg_next    = neg_next + CNT_W'(1);
         if (in_mag > peak_next)          peak_next   = in_mag;
      end
   end

   // Statistics registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         sample_count <= '0;
         neg_count    <= '0;
         peak_mag     <= '0;
      end else begin
         sample_count <= sample_next;
         neg_count    <= neg_next;
         peak_mag     <= peak_next;
      end
   end

endmodule

// File: tb/tb_gng_sign_split.sv
// tb_gng_sign_split
// Self-checking bench for gng_sign_split. A monitor on the falling edge keeps
// a queue of expected {sign, magnitude} entries and expected statistics,
// compares the DUT against them every cycle, then applies that cycle's
// handshakes. A second instance with 4-bit counters shares the stimulus so
// saturation can be observed quickly.
module tb_gng_sign_split;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_sign;
   logic [15:0] out_mag;
   logic        clr_stats;
   logic [15:0] sample_count;
   logic [15:0] neg_count;
   logic [15:0] peak_mag;

   logic        sat_in_ready;
   logic        sat_out_valid;
   logic        sat_out_sign;
   logic [15:0] sat_out_mag;
   logic [3:0]  sat_sample_count;
   logic [3:0]  sat_neg_count;
   logic [15:0] sat_peak_mag;

   int checks;
   int failures;

   typedef struct {
      logic        s;
      logic [15:0] m;
   } entry_t;

   entry_t      exp_q[$];
   int          n_samples;
   int          n_neg;
   logic [15:0] peak_ref;

   gng_sign_split #(.W(16), .DEPTH(DEPTH), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sign(out_sign), .out_mag(out_mag),
      .clr_stats(clr_stats),
      .sample_count(sample_count), .neg_count(neg_count), .peak_mag(peak_mag)
   );

   gng_sign_split #(.W(16), .DEPTH(DEPTH), .CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(sat_in_ready), .in_data(in_data),
      .out_valid(sat_out_valid), .out_ready(out_ready),
      .out_sign(sat_out_sign), .out_mag(sat_out_mag),
      .clr_stats(clr_stats),
      .sample_count(sat_sample_count), .neg_count(sat_neg_count),
      .peak_mag(sat_peak_mag)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something wedges the stimulus.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int satLimit(input int n, input int lim);
      return (n > lim) ? lim : n;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drives one cycle of inputs, then returns just after the next rising edge.
   task automatic applyStimulus(input logic v, input logic [15:0] d,
                                input logic ordy, input logic clr);
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      clr_stats = clr;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      clr_stats = 1'b0;
   endtask

   // Holds a sample until the DUT accepts it, within a bounded wait.
   task automatic sendSample(input logic [15:0] d, input logic ordy);
      logic accepted;
      accepted  = 1'b0;
      in_valid  = 1'b1;
      in_data   = d;
      out_ready = ordy;
      clr_stats = 1'b0;
      for (int i = 0; i < 20; i++) begin
         accepted = in_ready;
         @(posedge clk);
         #1;
         if (accepted) break;
      end
      in_valid = 1'b0;
      if (!accepted) begin
         checks++;
         failures++;
         $display("[TB] FAIL send_timeout: sample %0h never accepted", d);
      end
   endtask

   // Monitor and scoreboard: compare the DUT against the expected queue and
   // statistics, then fold in the handshakes that the next edge will perform.
   always @(negedge clk) begin
      entry_t e;
      int     v;
      int     size_before;
      checkOutput("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
      checkOutput("in_ready", {31'b0, in_ready}, {31'b0, exp_q.size() < DEPTH});
      if (exp_q.size() != 0) begin
         checkOutput("head_sign", {31'b0, out_sign}, {31'b0, exp_q[0].s});
         checkOutput("head_mag", {16'b0, out_mag}, {16'b0, exp_q[0].m});
      end
      checkOutput("sample_count", {16'b0, sample_count}, satLimit(n_samples, 65535));
      checkOutput("neg_count", {16'b0, neg_count}, satLimit(n_neg, 65535));
      checkOutput("peak_mag", {16'b0, peak_mag}, {16'b0, peak_ref});
      checkOutput("sat_sample_count", {28'b0, sat_sample_count}, satLimit(n_samples, 15));
      checkOutput("sat_neg_count", {28'b0, sat_neg_count}, satLimit(n_neg, 15));

      if (rst) begin
         exp_q.delete();
         n_samples = 0;
         n_neg     = 0;
         peak_ref  = 16'h0;
      end else begin
         size_before = exp_q.size();
         if (out_ready && size_before != 0) void'(exp_q.pop_front());
         if (clr_stats) begin
            n_samples = 0;
            n_neg     = 0;
            peak_ref  = 16'h0;
         end
         if (in_valid && size_before < DEPTH) begin
            v   = int'($signed(in_data));
            e.s = (v < 0);
            e.m = 16'((v < 0) ? -v : v);
            exp_q.push_back(e);
            n_samples++;
            if (e.s) n_neg++;
            if (e.m > peak_ref) peak_ref = e.m;
         end
      end
   end

   // Directed scenarios followed by a randomized run.
   initial begin
      checks    = 0;
      failures  = 0;
      n_samples = 0;
      n_neg     = 0;
      peak_ref  = 16'h0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 16'h0;
      out_ready = 1'b0;
      clr_stats = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset values.
      checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
      checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("rst_out_sign", {31'b0, out_sign}, 32'd0);
      checkOutput("rst_out_mag", {16'b0, out_mag}, 32'd0);

      // Basic conversion including zero and the most negative value.
      applyStimulus(1'b1, 16'h0005, 1'b1, 1'b0);
      checkOutput("first_latency", {31'b0, out_valid}, 32'd1);
      applyStimulus(1'b1, 16'hFFFB, 1'b1, 1'b0);
      applyStimulus(1'b1, 16'h0000, 1'b1, 1'b0);
      applyStimulus(1'b1, 16'h8000, 1'b1, 1'b0);
      checkOutput("min_sign", {31'b0, out_sign}, 32'd1);
      checkOutput("min_mag", {16'b0, out_mag}, 32'h8000);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkOutput("basic_samples", {16'b0, sample_count}, 32'd4);
      checkOutput("basic_neg", {16'b0, neg_count}, 32'd2);
      checkOutput("basic_peak", {16'b0, peak_mag}, 32'h8000);

      // Fill the FIFO with the consumer stalled.
      sendSample(16'h0011, 1'b0);
      sendSample(16'hFFEE, 1'b0);
      sendSample(16'h0013, 1'b0);
      sendSample(16'h0014, 1'b0);
      checkOutput("full_in_ready", {31'b0, in_ready}, 32'd0);
      applyStimulus(1'b1, 16'h0015, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h0015, 1'b0, 1'b0);
      checkOutput("still_full", {31'b0, in_ready}, 32'd0);
      sendSample(16'h0015, 1'b1);
      sendSample(16'hFFEA, 1'b1);
      repeat (6) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkOutput("drained_valid", {31'b0, out_valid}, 32'd0);

      // Stalled head must hold.
      applyStimulus(1'b1, 16'hFFFF, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
         checkOutput("hold_sign", {31'b0, out_sign}, 32'd1);
         checkOutput("hold_mag", {16'b0, out_mag}, 32'd1);
      end
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkOutput("hold_release", {31'b0, out_valid}, 32'd0);

      // Clear and push in the same cycle.
      applyStimulus(1'b1, 16'hFF00, 1'b0, 1'b1);
      checkOutput("clr_samples", {16'b0, sample_count}, 32'd1);
      checkOutput("clr_neg", {16'b0, neg_count}, 32'd1);
      checkOutput("clr_peak", {16'b0, peak_mag}, 32'h0100);
      checkOutput("clr_fifo_mag", {16'b0, out_mag}, 32'h0100);
      repeat (2) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);

      // Reset with entries queued.
      applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'hF234, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h0042, 1'b0, 1'b0);
      rst = 1'b1;
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
      rst = 1'b0;
      checkOutput("mid_rst_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("mid_rst_ready", {31'b0, in_ready}, 32'd1);
      checkOutput("mid_rst_samples", {16'b0, sample_count}, 32'd0);
      checkOutput("mid_rst_peak", {16'b0, peak_mag}, 32'd0);
      applyStimulus(1'b1, 16'h7FFF, 1'b0, 1'b0);
      checkOutput("post_rst_sign", {31'b0, out_sign}, 32'd0);
      checkOutput("post_rst_mag", {16'b0, out_mag}, 32'h7FFF);
      repeat (2) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);

      // Saturation of the narrow counters.
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b1);
      for (int i = 0; i < 20; i++)
         applyStimulus(1'b1, 16'h8000 | 16'($urandom), 1'b1, 1'b0);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkOutput("sat_samples_15", {28'b0, sat_sample_count}, 32'd15);
      checkOutput("sat_neg_15", {28'b0, sat_neg_count}, 32'd15);
      checkOutput("wide_samples_20", {16'b0, sample_count}, 32'd20);

      // Randomized traffic.
      for (int i = 0; i < 300; i++)
         applyStimulus(1'($urandom), 16'($urandom), 1'($urandom),
                       1'(($urandom % 16) == 0));
      repeat (8) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkOutput("queue_drained", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
